// File: rtl/yuv2rgb_mul_sched.sv
// YUV->RGB engine sharing one external 8x10 multiplier, one pixel per 6 cycles.
// Define YUV2RGB_MUL_SCHED_CLAMP_EN to saturate R/G/B to 0..255 instead of wrapping.
module yuv2rgb_mul_sched #(
    parameter logic [9:0] C_RV = 10'd359,
    parameter logic [9:0] C_GU = 10'd88,
    parameter logic [9:0] C_GV = 10'd183,
    parameter logic [9:0] C_BU = 10'd454
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_y,
    input  logic [7:0]  in_u,
    input  logic [7:0]  in_v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic [7:0]  mul_din0,
    output logic [9:0]  mul_din1,
    input  logic [17:0] mul_dout,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE, M_RV, M_GU, M_GV, M_BU, OUT
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [7:0]         y_q, y_d;
    logic [7:0]         u_q, u_d;
    logic [7:0]         v_q, v_d;
    logic signed [17:0] p_rv_q, p_rv_d;
    logic signed [17:0] p_gu_q, p_gu_d;
    logic signed [17:0] p_gv_q, p_gv_d;
    logic [7:0]         r_q, r_d;
    logic [7:0]         g_q, g_d;
    logic [7:0]         b_q, b_d;

    logic signed [18:0] s_r, s_g, s_b;
    logic signed [10:0] t_r, t_g, t_b;
    logic signed [10:0] r11, g11, b11;
    logic               accept;

    function automatic logic [7:0] limit(input logic signed [10:0] x);
`ifdef YUV2RGB_MUL_SCHED_CLAMP_EN
        if (x < 11'sd0)
            return 8'd0;
        if (x > 11'sd255)
            return 8'd255;
        return x[7:0];
`else
        return 8'(x);
`endif
    endfunction

    // BU product is consumed straight off the multiplier in M_BU
    always_comb begin
        s_r = 19'(p_rv_q) + 19'sd128;
        s_g = 19'(p_gu_q) + 19'(p_gv_q) + 19'sd128;
        s_b = 19'($signed(mul_dout)) + 19'sd128;
        t_r = 11'(s_r >>> 8);
        t_g = 11'(s_g >>> 8);
        t_b = 11'(s_b >>> 8);
        r11 = $signed({3'b000, y_q}) + t_r;
        g11 = $signed({3'b000, y_q}) - t_g;
        b11 = $signed({3'b000, y_q}) + t_b;
    end

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        y_d        = y_q;
        u_d        = u_q;
        v_d        = v_q;
        p_rv_d     = p_rv_q;
        p_gu_d     = p_gu_q;
        p_gv_d     = p_gv_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        mul_din0   = 8'd0;
        mul_din1   = 10'd0;
        accept     = (state_q == IDLE) && in_valid && in_ready_q;
        unique case (state_q)
            IDLE: begin
                if (!in_ready_q)
                    in_ready_d = 1'b1;
                if (accept) begin
                    state_d    = M_RV;
                    in_ready_d = 1'b0;
                    y_d        = in_y;
                    u_d        = {~in_u[7], in_u[6:0]};
                    v_d        = {~in_v[7], in_v[6:0]};
                end
            end
            M_RV: begin
                mul_din0 = v_q;
                mul_din1 = C_RV;
                p_rv_d   = $signed(mul_dout);
                state_d  = M_GU;
            end
            M_GU: begin
                mul_din0 = u_q;
                mul_din1 = C_GU;
                p_gu_d   = $signed(mul_dout);
                state_d  = M_GV;
            end
            M_GV: begin
                mul_din0 = v_q;
                mul_din1 = C_GV;
                p_gv_d   = $signed(mul_dout);
                state_d  = M_BU;
            end
            M_BU: begin
                mul_din0 = u_q;
                mul_din1 = C_BU;
                r_d      = limit(r11);
                g_d      = limit(g11);
                b_d      = limit(b11);
                state_d  = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            y_q        <= 8'd0;
            u_q        <= 8'd0;
            v_q        <= 8'd0;
            p_rv_q     <= 18'sd0;
            p_gu_q     <= 18'sd0;
            p_gv_q     <= 18'sd0;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            b_q        <= 8'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            y_q        <= y_d;
            u_q        <= u_d;
            v_q        <= v_d;
            p_rv_q     <= p_rv_d;
            p_gu_q     <= p_gu_d;
            p_gv_q     <= p_gv_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_r     = r_q;
    assign out_g     = g_q;
    assign out_b     = b_q;
endmodule

// File: tb/tb_yuv2rgb_mul_sched.sv
// Bench for yuv2rgb_mul_sched: arithmetic reference model, per-cycle compare,
// plus hand-computed literal pixels and handshake/reset scenarios.
module tb_yuv2rgb_mul_sched;
    localparam int C_RV = 359;
    localparam int C_GU = 88;
    localparam int C_GV = 183;
    localparam int C_BU = 454;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_y = 8'd0;
    logic [7:0]  in_u = 8'd0;
    logic [7:0]  in_v = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_r, out_g, out_b;
    logic [7:0]  mul_din0;
    logic [9:0]  mul_din1;
    logic [17:0] mul_dout;
    logic        busy;

    int vecs = 0;
    int errs = 0;
    logic [23:0] exp_q[$];

    yuv2rgb_mul_sched #(
        .C_RV(10'(C_RV)), .C_GU(10'(C_GU)),
        .C_GV(10'(C_GV)), .C_BU(10'(C_BU))
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_u(in_u), .in_v(in_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout), .busy(busy)
    );

    // external combinational multiplier
    assign mul_dout = 18'($signed({{10{mul_din0[7]}}, mul_din0})
                        * $signed({8'd0, mul_din1}));

    always #5 ap_clk = ~ap_clk;

    function automatic int lim(int x);
`ifdef YUV2RGB_MUL_SCHED_CLAMP_EN
        if (x < 0) return 0;
        if (x > 255) return 255;
        return x;
`else
        return x & 255;
`endif
    endfunction

    function automatic logic [23:0] model(int y, int u, int v);
        int up, vp, tr, tg, tb;
        up = u - 128;
        vp = v - 128;
        tr = (vp * C_RV + 128) >>> 8;
        tg = (up * C_GU + vp * C_GV + 128) >>> 8;
        tb = (up * C_BU + 128) >>> 8;
        return {8'(lim(y + tr)), 8'(lim(y - tg)), 8'(lim(y + tb))};
    endfunction

    task automatic chk(string name, int act, int expv);
        vecs++;
        if (act != expv) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, expv, expv, $time);
        end
    endtask

    always @(posedge ap_clk) begin
        if (ap_rst_n) begin
            if (out_valid && out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (in_valid && in_ready)
                exp_q.push_back(model(in_y, in_u, in_v));
        end
    end

    always @(negedge ap_rst_n) exp_q.delete();

    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0)
                    chk("spurious out_valid", 1, 0);
                else
                    chk("rgb vs model", {out_r, out_g, out_b}, exp_q[0]);
            end
            chk("in_ready while busy", int'(in_ready && busy), 0);
            if (!busy)
                chk("operands outside M", {mul_din0, mul_din1}, 0);
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] y, u, v);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("in_ready timeout", 0, 1);
        in_valid = 1'b1;
        in_y = y;
        in_u = u;
        in_v = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [23:0] rgb);
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (!out_valid) chk("out_valid timeout", 0, 1);
        rgb = {out_r, out_g, out_b};
    endtask

    initial begin
        logic [23:0] cap;
        int d0[4];
        int d1[4];
        int n;
        d0 = '{178, 72, 178, 72};
        d1 = '{359, 88, 183, 454};

        #12;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst rgb", {out_r, out_g, out_b}, 0);
        chk("rst operands", {mul_din0, mul_din1}, 0);
        #10 ap_rst_n = 1'b1;
        chk("in_ready before 1st edge", in_ready, 0);
        step();
        chk("in_ready after 1st edge", in_ready, 1);

        accept(8'd128, 8'd128, 8'd128);
        for (int i = 0; i < 4; i++) begin
            chk("grey din0", mul_din0, 0);
            step();
        end
        wait_out(cap);
        chk("grey rgb literal", cap, 24'h808080);
        step();

        accept(8'd100, 8'd200, 8'd50);
        for (int i = 0; i < 4; i++) begin
            chk("seq out_valid low", out_valid, 0);
            chk("seq din0", mul_din0, d0[i]);
            chk("seq din1", mul_din1, d1[i]);
            step();
        end
        chk("seq out_valid after k+4", out_valid, 1);
        step();
        chk("in_ready after k+5", in_ready, 1);
        chk("idle after k+5", busy, 0);

        accept(8'd255, 8'd128, 8'd255);
        chk("back-to-back accepted", busy, 1);
        wait_out(cap);
`ifdef YUV2RGB_MUL_SCHED_CLAMP_EN
        chk("sat rgb literal", cap, {8'd255, 8'd164, 8'd255});
`else
        chk("wrap rgb literal", cap, {8'd177, 8'd164, 8'd255});
`endif
        step();

        accept(8'd0, 8'd0, 8'd0);
        wait_out(cap);
`ifdef YUV2RGB_MUL_SCHED_CLAMP_EN
        chk("zero rgb literal", cap, {8'd0, 8'd135, 8'd0});
`else
        chk("zero rgb literal", cap, {8'd77, 8'd135, 8'd29});
`endif
        step();

        out_ready = 1'b0;
        accept(8'd50, 8'd90, 8'd160);
        wait_out(cap);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2 == 0);
            in_y = 8'(i * 7);
            in_u = 8'(i * 13);
            in_v = 8'(i * 29);
            step();
            chk("hold rgb stable", {out_r, out_g, out_b}, cap);
            chk("hold out_valid", out_valid, 1);
            chk("hold in_ready", in_ready, 0);
            chk("hold operands", {mul_din0, mul_din1}, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("release out_valid", out_valid, 0);
        chk("release in_ready", in_ready, 1);

        accept(8'd200, 8'd30, 8'd220);
        step();
        step();
        chk("in M_GV", {mul_din0, mul_din1}, {8'd92, 10'd183});
        ap_rst_n = 1'b0;
        #1;
        chk("abort out_valid", out_valid, 0);
        chk("abort in_ready", in_ready, 0);
        chk("abort busy", busy, 0);
        chk("abort rgb", {out_r, out_g, out_b}, 0);
        chk("abort operands", {mul_din0, mul_din1}, 0);
        #1 ap_rst_n = 1'b1;
        chk("abort in_ready pre-edge", in_ready, 0);
        step();
        chk("abort in_ready 1st edge", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("abort no out_valid", out_valid, 0);
            step();
        end
        accept(8'd0, 8'd0, 8'd0);
        wait_out(cap);
        chk("after abort pixel", cap, model(0, 0, 0));
        step();

        accept(8'd16, 8'd240, 8'd16);
        accept(8'd235, 8'd16, 8'd240);
        accept(8'd81, 8'd90, 8'd240);
        accept(8'd145, 8'd54, 8'd34);
        n = 0;
        while ((exp_q.size() > 0 || busy) && n < 50) begin
            step();
            n++;
        end
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
